// File: rtl/spi_regs_pkg.sv
// Shared register map for the SPI command decoder and its APB register bank.
// Holds addresses, the chip ID default, STATUS bit positions and the byte-strobe merge helper.
package spi_regs_pkg;

  localparam logic [9:0] ADDR_CTRL      = 10'h000;
  localparam logic [9:0] ADDR_ERR_DATA  = 10'h004;
  localparam logic [9:0] ADDR_ERR_INFO  = 10'h008;
  localparam logic [9:0] ADDR_STATUS    = 10'h00C;
  localparam logic [9:0] ADDR_STIM_MASK = 10'h010;
  localparam logic [9:0] ADDR_SCRATCH   = 10'h014;
  localparam logic [9:0] ADDR_CHIP_ID   = 10'h018;

  localparam logic [31:0] CHIP_ID_DEFAULT = 32'h0101_0164;

  localparam int STATUS_CRC_ERR_BIT = 0;
  localparam int STATUS_ERR_CNT_LSB = 16;
  localparam int STATUS_ERR_CNT_MSB = 31;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_ERR_DATA,
    REG_ERR_INFO,
    REG_STATUS,
    REG_STIM_MASK,
    REG_SCRATCH,
    REG_CHIP_ID,
    REG_NONE
  } reg_sel_e;

  // Replaces only the byte lanes whose strobe is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_apb_regfile.sv
// APB slave register bank behind the SPI command decoder: stimulator mask, CRC error log/counter,
// scratch and chip ID. Read data is combinational so the decoder can capture it in the setup cycle.
module spi_apb_regfile
  import spi_regs_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 32,
  parameter int          ERRCNT_W    = 16,
  parameter logic [31:0] CHIP_ID_VAL = CHIP_ID_DEFAULT
) (
  input  logic              spi_clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] apb_addr_i,
  input  logic              apb_sel_i,
  input  logic              apb_enable_i,
  input  logic              apb_write_i,
  input  logic [DATA_W-1:0] apb_wdata_i,
  input  logic [3:0]        apb_strb_i,
  input  logic [2:0]        apb_prot_i,
  output logic [DATA_W-1:0] apb_rdata_o,
  output logic              apb_ready_o,
  output logic              apb_slverr_o,
  output logic [7:0]        stim_mask_en_o,
  output logic              crc_err_o
);

  logic                ready_q;
  logic [31:0]         ctrl_q;
  logic [31:0]         err_data_q;
  logic [8:0]          err_info_q;
  logic                crc_err_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic [7:0]          stim_mask_q;
  logic [31:0]         scratch_q;

  reg_sel_e    reg_sel;
  logic        unaligned;
  logic        addr_err;
  logic        access;
  logic        wr_commit;
  logic [31:0] status_word;
  logic [31:0] reg_word;
  logic [31:0] merged;
  logic        prot_unused;

  assign prot_unused = ^apb_prot_i;

  function automatic logic [ADDR_W-3:0] word_of(input logic [9:0] a);
    return (ADDR_W-2)'(a[9:2]);
  endfunction

  assign unaligned = |apb_addr_i[1:0];

  // Unaligned accesses decode to no register so they read back as zero.
  always_comb begin
    reg_sel = REG_NONE;
    if (!unaligned) begin
      if      (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_CTRL))      reg_sel = REG_CTRL;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_ERR_DATA))  reg_sel = REG_ERR_DATA;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_ERR_INFO))  reg_sel = REG_ERR_INFO;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_STATUS))    reg_sel = REG_STATUS;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_STIM_MASK)) reg_sel = REG_STIM_MASK;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_SCRATCH))   reg_sel = REG_SCRATCH;
      else if (apb_addr_i[ADDR_W-1:2] == word_of(ADDR_CHIP_ID))   reg_sel = REG_CHIP_ID;
    end
  end

  assign addr_err  = (reg_sel == REG_NONE) | (apb_write_i & (reg_sel == REG_CHIP_ID));
  assign access    = apb_sel_i & apb_enable_i;
  assign wr_commit = access & apb_write_i & ready_q & ~addr_err;

  always_comb begin
    status_word = '0;
    status_word[STATUS_CRC_ERR_BIT] = crc_err_q;
    status_word[STATUS_ERR_CNT_LSB +: ERRCNT_W] = err_cnt_q;
  end

  always_comb begin
    reg_word = '0;
    case (reg_sel)
      REG_CTRL:      reg_word = ctrl_q;
      REG_ERR_DATA:  reg_word = err_data_q;
      REG_ERR_INFO:  reg_word = {23'd0, err_info_q};
      REG_STATUS:    reg_word = status_word;
      REG_STIM_MASK: reg_word = {24'd0, stim_mask_q};
      REG_SCRATCH:   reg_word = scratch_q;
      REG_CHIP_ID:   reg_word = CHIP_ID_VAL;
      default:       reg_word = '0;
    endcase
  end

  assign merged = apply_strb(reg_word, apb_wdata_i[31:0], apb_strb_i);

  always_ff @(posedge spi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q     <= 1'b0;
      ctrl_q      <= '0;
      err_data_q  <= '0;
      err_info_q  <= '0;
      crc_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      stim_mask_q <= '0;
      scratch_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (wr_commit) begin
        case (reg_sel)
          REG_CTRL:     ctrl_q     <= merged;
          REG_ERR_DATA: err_data_q <= merged;
          // Logging an error counts it regardless of strobes; the counter holds at all-ones.
          REG_ERR_INFO: begin
            err_info_q <= merged[8:0];
            crc_err_q  <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          end
          REG_STATUS: begin
            if (apb_strb_i[0] & apb_wdata_i[STATUS_CRC_ERR_BIT]) begin
              crc_err_q <= 1'b0;
              err_cnt_q <= '0;
            end
          end
          REG_STIM_MASK: stim_mask_q <= merged[7:0];
          REG_SCRATCH:   scratch_q   <= merged;
          default:       ;
        endcase
      end
    end
  end

  assign apb_ready_o    = ready_q;
  assign apb_rdata_o    = apb_sel_i ? DATA_W'(reg_word) : '0;
  assign apb_slverr_o   = access & addr_err;
  assign stim_mask_en_o = stim_mask_q;
  assign crc_err_o      = crc_err_q;

endmodule

// File: tb/tb_spi_apb_regfile.sv
// Directed bench for spi_apb_regfile with a register-map model checked every cycle
// and hand-computed expectations at the key points of each scenario.
module tb_spi_apb_regfile;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic [9:0]  addr;
  logic        sel, en, wr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] rdata;
  logic        ready, slverr, crc_err;
  logic [7:0]  stim;

  int vectors = 0;
  int miscompares = 0;

  spi_apb_regfile #(.ERRCNT_W(CNT_W)) dut (
    .spi_clk_i(clk), .rst_n_i(rst_n), .apb_addr_i(addr), .apb_sel_i(sel),
    .apb_enable_i(en), .apb_write_i(wr), .apb_wdata_i(wdata), .apb_strb_i(strb),
    .apb_prot_i(prot), .apb_rdata_o(rdata), .apb_ready_o(ready),
    .apb_slverr_o(slverr), .stim_mask_en_o(stim), .crc_err_o(crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register map model
  logic        m_ready = 0;
  logic [31:0] m_ctrl = 0, m_errdata = 0, m_scratch = 0;
  logic [8:0]  m_errinfo = 0;
  logic [7:0]  m_mask = 0;
  logic        m_crc = 0;
  int          m_cnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic is_err(input logic [9:0] a, input logic w);
    if (a[1:0] != 2'b00) return 1'b1;
    if (!(a inside {10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h018})) return 1'b1;
    return w && (a == 10'h018);
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a)
      10'h000: return m_ctrl;
      10'h004: return m_errdata;
      10'h008: return {23'd0, m_errinfo};
      10'h00C: return (m_cnt << 16) | {31'd0, m_crc};
      10'h010: return {24'd0, m_mask};
      10'h014: return m_scratch;
      10'h018: return 32'h0101_0164;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    t = merge(m_read(a), d, s);
    case (a)
      10'h000: m_ctrl = t;
      10'h004: m_errdata = t;
      10'h008: begin
        m_errinfo = t[8:0];
        m_crc = 1'b1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
      10'h00C: if (s[0] && d[0]) begin m_crc = 1'b0; m_cnt = 0; end
      10'h010: m_mask = t[7:0];
      10'h014: m_scratch = t;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_ctrl = 0; m_errdata = 0; m_scratch = 0;
      m_errinfo = 0; m_mask = 0; m_crc = 0; m_cnt = 0;
    end else begin
      if (sel && en && wr && m_ready && !is_err(addr, wr)) m_write(addr, wdata, strb);
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rdata", rdata, sel ? m_read(addr) : 32'h0);
    chk("slverr", {31'd0, slverr}, {31'd0, sel && en && is_err(addr, wr)});
    chk("stim_mask", {24'd0, stim}, {24'd0, m_mask});
    chk("crc_err", {31'd0, crc_err}, {31'd0, m_crc});
  end

  // One full transfer starting just after a rising edge; optional literal check of setup-phase rdata.
  task automatic xfer(input logic [9:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    addr = a; wr = w; wdata = d; strb = s; sel = 1'b1; en = 1'b0;
    @(negedge clk);
    if (chk_rd) chk("setup_rdata", rdata, exp_rd);
    chk("setup_slverr", {31'd0, slverr}, 32'd0);
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    chk("access_slverr", {31'd0, slverr}, {31'd0, exp_err});
    @(posedge clk); #1;
    sel = 1'b0; en = 1'b0;
  endtask

  task automatic wr_reg(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, input logic e);
    xfer(a, 1'b1, d, s, 1'b0, 32'h0, e);
  endtask

  task automatic rd_reg(input logic [9:0] a, input logic [31:0] exp, input logic e);
    xfer(a, 1'b0, 32'h0, 4'h0, 1'b1, exp, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; addr = '0; sel = 0; en = 0; wr = 0; wdata = '0; strb = '0; prot = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'd0, ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    rd_reg(10'h018, 32'h0101_0164, 1'b0);

    wr_reg(10'h014, 32'hA5A5_1234, 4'b0101, 1'b0);
    rd_reg(10'h014, 32'h00A5_0034, 1'b0);
    wr_reg(10'h014, 32'hCAFE_F00D, 4'b1111, 1'b0);
    rd_reg(10'h014, 32'hCAFE_F00D, 1'b0);
    wr_reg(10'h000, 32'h1357_9BDF, 4'b1000, 1'b0);
    rd_reg(10'h000, 32'h1300_0000, 1'b0);

    wr_reg(10'h004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    wr_reg(10'h008, 32'h0000_01A3, 4'b1111, 1'b0);
    rd_reg(10'h008, 32'h0000_01A3, 1'b0);
    rd_reg(10'h00C, 32'h0001_0001, 1'b0);
    chk("crc_err_set", {31'd0, crc_err}, 32'd1);
    rd_reg(10'h004, 32'hDEAD_BEEF, 1'b0);

    wr_reg(10'h008, 32'hFFFF_FE55, 4'b0000, 1'b0);
    rd_reg(10'h00C, 32'h0002_0001, 1'b0);
    rd_reg(10'h008, 32'h0000_01A3, 1'b0);
    wr_reg(10'h008, 32'h0000_0055, 4'b1111, 1'b0);
    rd_reg(10'h00C, 32'h0003_0001, 1'b0);
    wr_reg(10'h008, 32'h0000_0055, 4'b1111, 1'b0);
    rd_reg(10'h00C, 32'h0003_0001, 1'b0);
    wr_reg(10'h00C, 32'h0000_0001, 4'b1110, 1'b0);
    rd_reg(10'h00C, 32'h0003_0001, 1'b0);
    wr_reg(10'h00C, 32'h0000_0001, 4'b0001, 1'b0);
    rd_reg(10'h00C, 32'h0000_0000, 1'b0);
    chk("crc_err_cleared", {31'd0, crc_err}, 32'd0);

    wr_reg(10'h018, 32'h1111_1111, 4'b1111, 1'b1);
    rd_reg(10'h018, 32'h0101_0164, 1'b0);
    wr_reg(10'h01C, 32'h2222_2222, 4'b1111, 1'b1);
    rd_reg(10'h01C, 32'h0000_0000, 1'b1);
    rd_reg(10'h002, 32'h0000_0000, 1'b1);
    wr_reg(10'h016, 32'h3333_3333, 4'b1111, 1'b1);
    rd_reg(10'h014, 32'hCAFE_F00D, 1'b0);

    wr_reg(10'h010, 32'hFFFF_FF81, 4'b1111, 1'b0);
    @(negedge clk);
    chk("stim_mask_set", {24'd0, stim}, 32'h81);
    @(posedge clk); #1;
    addr = 10'h014; wr = 1'b1; wdata = 32'h1234_5678; strb = 4'hF; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("stim_mask_reset", {24'd0, stim}, 32'h0);
    chk("ready_reset_mid", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    sel = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_reg(10'h014, 32'h0000_0000, 1'b0);
    rd_reg(10'h010, 32'h0000_0000, 1'b0);
    rd_reg(10'h018, 32'h0101_0164, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
